// File: rtl/i2s_speaker_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_speaker_tx
// Purpose  : I2S bus-controller transmitter. Generates sck/ws from clk_in and
//            shifts one buffered stereo PCM pair per frame, MSB first, toward
//            an I2S DAC/amplifier. Samples arrive on a valid/ready stream into
//            a one-entry holding buffer.
// Ports    : clk_in            system clock
//            rst_in            asynchronous reset, active-low
//            left_in/right_in  PCM pair, captured on valid && ready
//            sample_valid_in   pair offered
//            sample_ready_out  holding buffer empty
//            spk_sck           I2S bit clock
//            spk_ws            word select (0 = left, 1 = right)
//            spk_data          serial data, changes only on sck fall
//            underrun_out      1-cycle pulse when a frame starts with no pair
// Revision : 1.0  initial release
// ============================================================================
module i2s_speaker_tx #(
    parameter int CLK_DIV      = 16,
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [SAMPLE_WIDTH-1:0] left_in,
    input  logic [SAMPLE_WIDTH-1:0] right_in,
    input  logic                    sample_valid_in,
    output logic                    sample_ready_out,
    output logic                    spk_sck,
    output logic                    spk_ws,
    output logic                    spk_data,
    output logic                    underrun_out
);

    localparam int c_FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int c_DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_BIT_W      = $clog2(c_FRAME_BITS);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(c_FRAME_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_WS_FIRST = c_BIT_W'(SLOT_WIDTH - 1);
    localparam logic [c_BIT_W-1:0] c_WS_LAST  = c_BIT_W'(c_FRAME_BITS - 2);

    logic [c_DIV_W-1:0]      r_div_cnt;
    logic                    r_sck;
    logic [c_BIT_W-1:0]      r_bit_cnt;
    logic                    r_ws;
    logic                    r_data;
    logic                    r_underrun;
    logic [c_FRAME_BITS-1:0] r_shift;
    logic                    r_buf_full;
    logic [SAMPLE_WIDTH-1:0] r_buf_l;
    logic [SAMPLE_WIDTH-1:0] r_buf_r;

    logic                    w_div_wrap;
    logic                    w_sck_fall;
    logic [c_BIT_W-1:0]      w_bit_next;
    logic                    w_ws_next;
    logic                    w_frame_load;
    logic                    w_accept;
    logic [SLOT_WIDTH-1:0]   w_slot_l;
    logic [SLOT_WIDTH-1:0]   w_slot_r;
    logic [c_FRAME_BITS-1:0] w_frame;

    assign w_div_wrap   = (r_div_cnt == c_DIV_LAST);
    assign w_sck_fall   = w_div_wrap && r_sck;
    assign w_bit_next   = (r_bit_cnt == c_BIT_LAST) ? '0 : r_bit_cnt + c_BIT_W'(1);
    // ws leads each slot by one bit: high from the last left bit up to the
    // second-to-last right bit.
    assign w_ws_next    = (w_bit_next >= c_WS_FIRST) && (w_bit_next <= c_WS_LAST);
    assign w_frame_load = w_sck_fall && (w_bit_next == '0);
    assign w_accept     = sample_valid_in && !r_buf_full;

    // Samples are left-justified in their slots; unused LSBs transmit zero.
    assign w_slot_l = SLOT_WIDTH'(r_buf_l) << (SLOT_WIDTH - SAMPLE_WIDTH);
    assign w_slot_r = SLOT_WIDTH'(r_buf_r) << (SLOT_WIDTH - SAMPLE_WIDTH);
    // An empty buffer at frame start yields a silent frame.
    assign w_frame  = r_buf_full ? {w_slot_l, w_slot_r} : '0;

    // Bit clock divider
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_div_cnt <= '0;
            r_sck     <= 1'b0;
        end else begin
            if (w_div_wrap) begin
                r_div_cnt <= '0;
                r_sck     <= ~r_sck;
            end else begin
                r_div_cnt <= r_div_cnt + c_DIV_W'(1);
            end
        end
    end

    // Serialiser: every output change happens on the sck-fall clk edge
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_bit_cnt  <= c_BIT_LAST;
            r_ws       <= 1'b0;
            r_data     <= 1'b0;
            r_shift    <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_frame_load && !r_buf_full;
            if (w_sck_fall) begin
                r_bit_cnt <= w_bit_next;
                r_ws      <= w_ws_next;
                if (w_frame_load) begin
                    r_data  <= w_frame[c_FRAME_BITS-1];
                    r_shift <= {w_frame[c_FRAME_BITS-2:0], 1'b0};
                end else begin
                    r_data  <= r_shift[c_FRAME_BITS-1];
                    r_shift <= {r_shift[c_FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

    // One-entry holding buffer. A pair accepted on the load edge itself is
    // kept for the following frame; the load sees the pre-accept state.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_buf_full <= 1'b0;
            r_buf_l    <= '0;
            r_buf_r    <= '0;
        end else begin
            if (w_accept) begin
                r_buf_full <= 1'b1;
                r_buf_l    <= left_in;
                r_buf_r    <= right_in;
            end else if (w_frame_load) begin
                r_buf_full <= 1'b0;
            end
        end
    end

    assign sample_ready_out = !r_buf_full;
    assign spk_sck          = r_sck;
    assign spk_ws           = r_ws;
    assign spk_data         = r_data;
    assign underrun_out     = r_underrun;

endmodule
`default_nettype wire
